// File: rtl/reg_fifo_if.sv
// Producer/consumer handshake bundle for reg_fifo: write side, read side, flush and occupancy.
// The slave modport is the FIFO; the master modport is whoever drives it.
interface reg_fifo_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] wr_data_i;
   logic             wr_valid_i;
   logic             wr_ready_o;
   logic [WIDTH-1:0] rd_data_o;
   logic             rd_valid_o;
   logic             rd_ready_i;
   logic             flush_i;
   logic [CNT_W-1:0] count_o;

   modport slave (
      input  wr_data_i, wr_valid_i, rd_ready_i, flush_i,
      output wr_ready_o, rd_data_o, rd_valid_o, count_o
   );

   modport master (
      output wr_data_i, wr_valid_i, rd_ready_i, flush_i,
      input  wr_ready_o, rd_data_o, rd_valid_o, count_o
   );
endinterface

// File: rtl/reg_fifo.sv
// Register-based synchronous FIFO with first-word fall-through, occupancy count and flush.
// Ready/valid are decoded from the registered count only, so no rd_ready -> wr_ready path exists.
module reg_fifo #(
   parameter int               WIDTH     = 16,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input logic        clk_i,
   input logic        reset_i,
   reg_fifo_if.slave  bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full, empty, push, pop;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) return '0;
      else                        return p + PTR_W'(1);
   endfunction

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.wr_valid_i && !full;
   assign pop   = bus.rd_ready_i && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is never reset; stale words are masked by the empty check on the output.
   always_ff @(posedge clk_i) begin
      if (push && !bus.flush_i && !reset_i) mem_q[wr_ptr_q] <= bus.wr_data_i;
   end

   assign bus.wr_ready_o = !full;
   assign bus.rd_valid_o = !empty;
   assign bus.rd_data_o  = empty ? RESET_VAL : mem_q[rd_ptr_q];
   assign bus.count_o    = count_q;
endmodule

// File: tb/tb_reg_fifo.sv
// Directed bench for reg_fifo: a DEPTH=4 instance for fill/drain/flush/reset and a DEPTH=3
// instance for streaming across the pointer wrap.
module tb_reg_fifo;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   reg_fifo_if #(.WIDTH(16), .DEPTH(4)) a_if ();
   reg_fifo_if #(.WIDTH(16), .DEPTH(3)) b_if ();

   reg_fifo #(.WIDTH(16), .DEPTH(4), .RESET_VAL(16'h0000)) u_a (
      .clk_i(clk), .reset_i(rst), .bus(a_if.slave));
   reg_fifo #(.WIDTH(16), .DEPTH(3), .RESET_VAL(16'h0000)) u_b (
      .clk_i(clk), .reset_i(rst), .bus(b_if.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_idle();
      a_if.wr_valid_i = 1'b0;
      a_if.rd_ready_i = 1'b0;
      a_if.flush_i    = 1'b0;
   endtask

   task automatic a_push(input logic [15:0] d);
      a_if.wr_valid_i = 1'b1;
      a_if.wr_data_i  = d;
      tick();
      a_if.wr_valid_i = 1'b0;
   endtask

   task automatic a_pop_chk(input string tag, input logic [15:0] exp);
      chk(tag, {16'h0, a_if.rd_data_o}, {16'h0, exp});
      a_if.rd_ready_i = 1'b1;
      tick();
      a_if.rd_ready_i = 1'b0;
   endtask

   task automatic a_empty_chk(input string tag);
      chk({tag, "_cnt"},  32'(a_if.count_o), 32'd0);
      chk({tag, "_vld"},  32'(a_if.rd_valid_o), 32'd0);
      chk({tag, "_rdy"},  32'(a_if.wr_ready_o), 32'd1);
      chk({tag, "_data"}, {16'h0, a_if.rd_data_o}, 32'h0);
   endtask

   initial begin
      a_if.wr_data_i = 16'h0;
      b_if.wr_data_i = 16'h0;
      b_if.wr_valid_i = 1'b0;
      b_if.rd_ready_i = 1'b0;
      b_if.flush_i    = 1'b0;
      a_idle();

      // Reset held for two edges, then idle state
      rst = 1'b1;
      tick();
      tick();
      a_empty_chk("reset");
      chk("reset_b_cnt", 32'(b_if.count_o), 32'd0);
      rst = 1'b0;
      tick();
      a_empty_chk("idle");

      // Fill to full; first word falls through immediately
      a_push(16'h1111);
      chk("fwft_vld", 32'(a_if.rd_valid_o), 32'd1);
      chk("fwft_data", {16'h0, a_if.rd_data_o}, 32'h1111);
      chk("fwft_cnt", 32'(a_if.count_o), 32'd1);
      a_push(16'h2222);
      a_push(16'h3333);
      a_push(16'h4444);
      chk("full_cnt", 32'(a_if.count_o), 32'd4);
      chk("full_rdy", 32'(a_if.wr_ready_o), 32'd0);
      a_push(16'h5555);
      chk("over_cnt", 32'(a_if.count_o), 32'd4);
      chk("over_head", {16'h0, a_if.rd_data_o}, 32'h1111);

      a_pop_chk("drain0", 16'h1111);
      chk("drain_cnt3", 32'(a_if.count_o), 32'd3);
      chk("drain_rdy", 32'(a_if.wr_ready_o), 32'd1);
      a_pop_chk("drain1", 16'h2222);
      a_pop_chk("drain2", 16'h3333);
      a_pop_chk("drain3", 16'h4444);
      a_empty_chk("drained");

      // Full with simultaneous push and pop: only the pop happens
      a_push(16'h0101);
      a_push(16'h0202);
      a_push(16'h0303);
      a_push(16'h0404);
      a_if.wr_valid_i = 1'b1;
      a_if.wr_data_i  = 16'hAAAA;
      a_if.rd_ready_i = 1'b1;
      tick();
      a_idle();
      chk("fullpp_cnt", 32'(a_if.count_o), 32'd3);
      a_pop_chk("fullpp0", 16'h0202);
      a_pop_chk("fullpp1", 16'h0303);
      a_pop_chk("fullpp2", 16'h0404);
      a_empty_chk("fullpp_end");

      // Empty with simultaneous push and pop: only the push happens
      a_if.wr_valid_i = 1'b1;
      a_if.wr_data_i  = 16'h0077;
      a_if.rd_ready_i = 1'b1;
      tick();
      a_idle();
      chk("emptypp_cnt", 32'(a_if.count_o), 32'd1);
      a_pop_chk("emptypp_data", 16'h0077);
      chk("emptypp_end", 32'(a_if.count_o), 32'd0);

      // Flush beats a concurrent push and pop
      a_push(16'h0A0A);
      a_push(16'h0B0B);
      chk("preflush_cnt", 32'(a_if.count_o), 32'd2);
      a_if.flush_i    = 1'b1;
      a_if.wr_valid_i = 1'b1;
      a_if.wr_data_i  = 16'hBEEF;
      a_if.rd_ready_i = 1'b1;
      tick();
      a_idle();
      a_empty_chk("flush");
      a_push(16'h0001);
      chk("postflush_cnt", 32'(a_if.count_o), 32'd1);
      a_pop_chk("postflush_data", 16'h0001);
      a_empty_chk("postflush_end");

      // Streaming on DEPTH=3 with occupancy held at 1 across several wraps
      b_if.wr_valid_i = 1'b1;
      b_if.wr_data_i  = 16'd1;
      tick();
      chk("stream_start", 32'(b_if.count_o), 32'd1);
      for (int v = 2; v <= 10; v++) begin
         chk($sformatf("stream_data%0d", v - 1), {16'h0, b_if.rd_data_o}, 32'(v - 1));
         b_if.wr_data_i  = 16'(v);
         b_if.rd_ready_i = 1'b1;
         tick();
         chk($sformatf("stream_cnt%0d", v), 32'(b_if.count_o), 32'd1);
      end
      b_if.wr_valid_i = 1'b0;
      chk("stream_data10", {16'h0, b_if.rd_data_o}, 32'd10);
      tick();
      b_if.rd_ready_i = 1'b0;
      chk("stream_end_cnt", 32'(b_if.count_o), 32'd0);
      chk("stream_end_data", {16'h0, b_if.rd_data_o}, 32'h0);

      // Reset mid-operation during a push
      a_push(16'h0C01);
      a_push(16'h0C02);
      a_push(16'h0C03);
      chk("prereset_cnt", 32'(a_if.count_o), 32'd3);
      rst = 1'b1;
      a_if.wr_valid_i = 1'b1;
      a_if.wr_data_i  = 16'h9999;
      tick();
      rst = 1'b0;
      a_idle();
      a_empty_chk("midreset");
      a_push(16'h00C3);
      chk("postreset_cnt", 32'(a_if.count_o), 32'd1);
      a_pop_chk("postreset_data", 16'h00C3);
      a_empty_chk("postreset_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
